hazard_ctrl: RTL

Central pipeline hazard controller for the five-stage core. It takes the per-stage forwarding records from EX, MEM and WB, plus load, mul/div, redirect and memory-busy flags. From these it produces per-stage stall and flush controls and the rs1/rs2 bypass selections for the ID stage. It owns the only sequential hazard state in the core: the multi-cycle mul/div occupancy counter and the wrong-path fetch discard flag.

---
 rtl/hazard_ctrl_pkg.sv | 32 +++
 rtl/hazard_ctrl_fwd_select.sv | 30 +++
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: register/word types,
// per-stage forwarding records, bypass select encoding and controller states.
package hazard_ctrl_pkg;

    typedef logic        u1;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        u1          valid;
        creg_addr_t dst;
        word_t      data;
    } forward_data_out;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } hazard_state_t;

    // x0 is hardwired to zero, so a write to it must never be bypassed
    function automatic u1 stage_hit(input forward_data_out f, input creg_addr_t src);
        return f.valid && (f.dst == src) && (f.dst != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Combinational bypass mux for one ID source register, priority EX > MEM > WB.
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  creg_addr_t      src,
    input  forward_data_out ex_fwd,
    input  forward_data_out mem_fwd,
    input  forward_data_out wb_fwd,
    input  logic            ex_is_load,
    output fwd_sel_t        sel,
    output word_t           data
);

    // A load in EX has no data yet, so it is skipped and older stages may win
    always_comb begin
        sel  = FWD_RF;
        data = '0;
        if (!ex_is_load && stage_hit(ex_fwd, src)) begin
            sel  = FWD_EX;
            data = ex_fwd.data;
        end else if (stage_hit(mem_fwd, src)) begin
            sel  = FWD_MEM;
            data = mem_fwd.data;
        end else if (stage_hit(wb_fwd, src)) begin
            sel  = FWD_WB;
            data = wb_fwd.data;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: stall/flush generation, ID bypass selection,
// mul/div occupancy tracking and wrong-path fetch discard.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 64,
    parameter int CNT_W      = 7
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            id_valid,
    input  creg_addr_t      id_rs1,
    input  creg_addr_t      id_rs2,
    input  forward_data_out ex_fwd,
    input  forward_data_out mem_fwd,
    input  forward_data_out wb_fwd,
    input  logic            ex_is_load,
    input  logic            ex_muldiv_start,
    input  logic            ex_redirect,
    input  logic            imem_busy,
    input  logic            dmem_busy,
    output logic            stall_if,
    output logic            stall_id,
    output logic            stall_ex,
    output logic            stall_mem,
    output logic            flush_id,
    output logic            flush_ex,
    output fwd_sel_t        fwd_sel_rs1,
    output fwd_sel_t        fwd_sel_rs2,
    output word_t           fwd_rs1,
    output word_t           fwd_rs2,
    output logic            busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    hazard_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             redir_pend, redir_pend_nxt;

    logic load_use;
    logic muldiv_hold;
    logic kill;
    logic stall_ex_raw, stall_id_raw, stall_if_raw;
    logic flush_ex_raw, flush_id_raw;
    logic discard_fire;

    fwd_select u_fwd_rs1 (
        .src        (id_rs1),
        .ex_fwd     (ex_fwd),
        .mem_fwd    (mem_fwd),
        .wb_fwd     (wb_fwd),
        .ex_is_load (ex_is_load),
        .sel        (fwd_sel_rs1),
        .data       (fwd_rs1)
    );

    fwd_select u_fwd_rs2 (
        .src        (id_rs2),
        .ex_fwd     (ex_fwd),
        .mem_fwd    (mem_fwd),
        .wb_fwd     (wb_fwd),
        .ex_is_load (ex_is_load),
        .sel        (fwd_sel_rs2),
        .data       (fwd_rs2)
    );

    assign load_use = id_valid && ex_fwd.valid && ex_is_load && (ex_fwd.dst != '0) &&
                      ((ex_fwd.dst == id_rs1) || (ex_fwd.dst == id_rs2));

    assign muldiv_hold = ((state == RUN) && ex_muldiv_start) ||
                         ((state == MULDIV) && (cnt != '0));

    // Priority falls out of the ordering: dmem, mul/div, redirect, load-use, fetch
    assign stall_ex_raw = dmem_busy || muldiv_hold;
    assign kill         = ex_redirect && !stall_ex_raw;
    assign stall_id_raw = stall_ex_raw || (load_use && !kill);
    assign stall_if_raw = stall_id_raw || imem_busy;
    assign flush_ex_raw = load_use && !stall_ex_raw && !kill;
    assign discard_fire = redir_pend && !imem_busy && !stall_id_raw;
    assign flush_id_raw = kill || discard_fire || (imem_busy && !stall_id_raw);

    assign stall_mem = resetn && dmem_busy;
    assign stall_ex  = resetn && stall_ex_raw;
    assign stall_id  = resetn && stall_id_raw;
    assign stall_if  = resetn && stall_if_raw;
    assign flush_ex  = resetn && flush_ex_raw;
    assign flush_id  = resetn && flush_id_raw;
    assign busy      = resetn && (state != RUN);

    // The counter keeps running under dmem_busy; only the exit waits for MEM
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (ex_muldiv_start && !dmem_busy) begin
                    state_nxt = MULDIV;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            MULDIV: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (!dmem_busy) begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    // A fresh redirect during an outstanding fetch outranks a same-cycle clear
    always_comb begin
        redir_pend_nxt = redir_pend;
        if (kill && imem_busy) begin
            redir_pend_nxt = 1'b1;
        end else if (discard_fire) begin
            redir_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RUN;
            cnt        <= '0;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            redir_pend <= redir_pend_nxt;
        end
    end

endmodule
